// File: rtl/aes_key_schedule_multi.sv
// aes_key_schedule_multi: run-time AES-128/192/256 key expansion, one schedule word per clock.
// Define AES_KS_RDPORT_EN to add a registered single-round-key read port.
module aes_key_schedule_multi #(
  parameter int MAX_NR       = 14,
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [1:0]                   key_len,
  input  logic [MAX_KEY_BITS-1:0]      key_in,
`ifdef AES_KS_RDPORT_EN
  input  logic                         rk_rd_en,
  input  logic [3:0]                   rk_rd_idx,
  output logic [127:0]                 rk_rd_data,
  output logic                         rk_rd_vld,
`endif
  output logic                         busy,
  output logic                         done,
  output logic                         keys_valid,
  output logic                         err,
  output logic [3:0]                   nr_out,
  output logic [(MAX_NR+1)*128-1:0]    keys_out
);
  localparam int NW = 4 * (MAX_NR + 1);
  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  state_t      r_state;
  logic [31:0] r_w [NW];
  logic [5:0]  r_i;
  logic [3:0]  r_nk;
  logic [3:0]  r_pos;
  logic [3:0]  r_nr;
  logic [7:0]  r_rc;
  logic        r_busy;
  logic        r_done;
  logic        r_kv;
  logic        r_err;
  logic [3:0]  w_nr;
  logic [3:0]  w_nk;
  logic        w_legal;
  logic        w_idle;
  logic        w_accept;
  logic        w_reject;
  logic        w_last;
  logic [31:0] w_prev;
  logic [31:0] w_back;
  logic [31:0] w_rot;
  logic [31:0] w_sub;
  logic [31:0] w_temp;
  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction
  // r_pos tracks i mod Nk and r_rc the current Rcon byte, so no divider is needed
  always_comb begin
    w_nr     = (key_len == 2'd0) ? 4'd10 : (key_len == 2'd1) ? 4'd12 : (key_len == 2'd2) ? 4'd14 : 4'd0;
    w_nk     = w_nr - 4'd6;
    w_legal  = (key_len != 2'd3) && (int'(w_nr) <= MAX_NR);
    w_idle   = r_state != S_EXPAND;
    w_accept = start && w_idle && w_legal;
    w_reject = start && w_idle && !w_legal;
    w_prev   = r_w[r_i - 6'd1];
    w_back   = r_w[r_i - {2'b00, r_nk}];
    w_rot    = (r_pos == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    w_sub    = sub_word(w_rot);
    w_temp   = (r_pos == 4'd0) ? (w_sub ^ {r_rc, 24'h0}) : (r_nk == 4'd8 && r_pos == 4'd4) ? w_sub : w_prev;
    w_last   = r_i == {r_nr, 2'b11};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_nk    <= '0;
      r_pos   <= '0;
      r_nr    <= '0;
      r_rc    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_kv    <= 1'b0;
      r_err   <= 1'b0;
      for (int k = 0; k < NW; k++) r_w[k] <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= w_reject;
      if (w_accept) begin
        for (int k = 0; k < NW; k++) r_w[k] <= '0;
        for (int k = 0; k < MAX_KEY_BITS / 32; k++)
          if (k < int'(w_nk)) r_w[k] <= key_in[MAX_KEY_BITS-1-32*k -: 32];
        r_state <= S_EXPAND;
        r_nr    <= w_nr;
        r_nk    <= w_nk;
        r_i     <= {2'b00, w_nk};
        r_pos   <= '0;
        r_rc    <= 8'h01;
        r_busy  <= 1'b1;
        r_kv    <= 1'b0;
      end else if (r_state == S_EXPAND) begin
        r_w[r_i] <= w_back ^ w_temp;
        r_i      <= r_i + 6'd1;
        r_pos    <= (r_pos == r_nk - 4'd1) ? 4'd0 : r_pos + 4'd1;
        r_rc     <= (r_pos == 4'd0) ? ({r_rc[6:0], 1'b0} ^ (r_rc[7] ? 8'h1b : 8'h00)) : r_rc;
        if (w_last) begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_kv    <= 1'b1;
          r_done  <= 1'b1;
        end
      end
    end
  end
  for (genvar g = 0; g < NW; g++) begin : g_out
    assign keys_out[(NW-g)*32-1 -: 32] = r_w[g];
  end
  assign busy       = r_busy;
  assign done       = r_done;
  assign keys_valid = r_kv;
  assign err        = r_err;
  assign nr_out     = r_nr;
`ifdef AES_KS_RDPORT_EN
  logic [127:0] r_rd_data;
  logic         r_rd_vld;
  logic         w_rd_ok;
  assign w_rd_ok = rk_rd_en && r_kv && (rk_rd_idx <= r_nr);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
    end else begin
      r_rd_vld  <= w_rd_ok;
      r_rd_data <= w_rd_ok ? {r_w[{rk_rd_idx, 2'b00}], r_w[{rk_rd_idx, 2'b01}],
                              r_w[{rk_rd_idx, 2'b10}], r_w[{rk_rd_idx, 2'b11}]} : '0;
    end
  end
  assign rk_rd_data = r_rd_data;
  assign rk_rd_vld  = r_rd_vld;
`endif
endmodule

// File: tb/tb_aes_key_schedule_multi.sv
// tb_aes_key_schedule_multi: random and known-answer checks of aes_key_schedule_multi
// against a FIPS-197 style key expansion model built on GF(2^8) arithmetic.
module tb_aes_key_schedule_multi;
  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     key_len = 2'd0;
  logic [255:0]   key_in = '0;
  logic           busy;
  logic           done;
  logic           keys_valid;
  logic           err;
  logic [3:0]     nr_out;
  logic [1919:0]  keys_out;
`ifdef AES_KS_RDPORT_EN
  logic           rk_rd_en = 1'b0;
  logic [3:0]     rk_rd_idx = 4'd0;
  logic [127:0]   rk_rd_data;
  logic           rk_rd_vld;
`endif
  int             n_checks = 0;
  int             n_errors = 0;
  logic [7:0]     sb [256];
  aes_key_schedule_multi #(.MAX_NR(14), .MAX_KEY_BITS(256)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .key_len(key_len),
    .key_in(key_in),
`ifdef AES_KS_RDPORT_EN
    .rk_rd_en(rk_rd_en),
    .rk_rd_idx(rk_rd_idx),
    .rk_rd_data(rk_rd_data),
    .rk_rd_vld(rk_rd_vld),
`endif
    .busy(busy),
    .done(done),
    .keys_valid(keys_valid),
    .err(err),
    .nr_out(nr_out),
    .keys_out(keys_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction
  function automatic logic [1919:0] model(input int len, input logic [255:0] key);
    logic [7:0]    rcon [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [1919:0] res = '0;
    int nk = 4 + 2 * len;
    int nr = nk + 6;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon[i/nk], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 60; i++) res[1919-32*i -: 32] = w[i];
    return res;
  endfunction
  function automatic logic [127:0] rk_of(input logic [1919:0] v, input int k);
    return v[(14-k)*128 +: 128];
  endfunction
  function automatic logic [255:0] rnd256;
    logic [255:0] r = '0;
    for (int n = 0; n < 8; n++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction
  task automatic run(input int len, input logic [255:0] key, input int inject_at);
    logic [1919:0] exp = model(len, key);
    int cnt = 0;
    logic saw_err = 1'b0;
    start = 1'b1;
    key_len = 2'(len);
    key_in = key;
    tick;
    start = 1'b0;
    check("acc_busy", 128'(busy), 128'd1);
    check("acc_kv", 128'(keys_valid), 128'd0);
    check("acc_nr", 128'(nr_out), 128'(10 + 2 * len));
    while (!done && cnt < 200) begin
      start = (cnt == inject_at);
      if (start) begin
        key_len = 2'($urandom_range(0, 3));
        key_in = rnd256();
      end
      tick;
      cnt++;
      saw_err = saw_err | err;
    end
    start = 1'b0;
    check("latency", 128'(cnt), 128'(40 + 6 * len));
    check("no_err", 128'(saw_err), 128'd0);
    check("done_kv", 128'(keys_valid), 128'd1);
    check("done_busy", 128'(busy), 128'd0);
    for (int k = 0; k < 15; k++) check($sformatf("rk%0d_len%0d", k, len), rk_of(keys_out, k), rk_of(exp, k));
    tick;
    check("done_pulse", 128'(done), 128'd0);
    check("kv_hold", 128'(keys_valid), 128'd1);
  endtask
  initial begin
    logic [1919:0] held;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    tick;
    tick;
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_kv", 128'(keys_valid), 128'd0);
    check("rst_err", 128'(err), 128'd0);
    check("rst_nr", 128'(nr_out), 128'd0);
    check("rst_keys", 128'(|keys_out), 128'd0);
    reset = 1'b0;
    tick;
    start = 1'b1;
    key_len = 2'd3;
    key_in = rnd256();
    tick;
    start = 1'b0;
    check("rej_err", 128'(err), 128'd1);
    check("rej_busy", 128'(busy), 128'd0);
    tick;
    check("rej_err_pulse", 128'(err), 128'd0);
    check("rej_keys", 128'(|keys_out), 128'd0);
    check("rej_busy2", 128'(busy), 128'd0);
    run(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, -1);
    check("kat128_rk10", rk_of(keys_out, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("kat128_nr", 128'(nr_out), 128'd10);
    for (int k = 11; k < 15; k++) check($sformatf("kat128_rk%0d_zero", k), rk_of(keys_out, k), 128'h0);
`ifdef AES_KS_RDPORT_EN
    rk_rd_en = 1'b1;
    rk_rd_idx = 4'd10;
    tick;
    rk_rd_en = 1'b0;
    check("rd10_data", rk_rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("rd10_vld", 128'(rk_rd_vld), 128'd1);
    rk_rd_en = 1'b1;
    rk_rd_idx = 4'd12;
    tick;
    rk_rd_en = 1'b0;
    check("rd12_vld", 128'(rk_rd_vld), 128'd0);
    check("rd12_data", rk_rd_data, 128'h0);
`endif
    held = keys_out;
    start = 1'b1;
    key_len = 2'd3;
    tick;
    start = 1'b0;
    check("done_rej_err", 128'(err), 128'd1);
    tick;
    check("done_rej_kv", 128'(keys_valid), 128'd1);
    check("done_rej_keys", 128'(keys_out === held), 128'd1);
    check("done_rej_busy", 128'(busy), 128'd0);
    run(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, -1);
    check("kat192_rk12", rk_of(keys_out, 12), 128'he98ba06f448c773c8ecc720401002202);
    check("kat192_nr", 128'(nr_out), 128'd12);
    run(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, -1);
    check("kat256_rk14", rk_of(keys_out, 14), 128'hfe4890d1e6188d0b046df344706c631e);
    run(2, rnd256(), 10);
    start = 1'b1;
    key_len = 2'd2;
    key_in = rnd256();
    tick;
    start = 1'b0;
    repeat (19) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_done", 128'(done), 128'd0);
    check("mid_rst_kv", 128'(keys_valid), 128'd0);
    check("mid_rst_err", 128'(err), 128'd0);
    check("mid_rst_nr", 128'(nr_out), 128'd0);
    check("mid_rst_keys", 128'(|keys_out), 128'd0);
    tick;
    check("post_rst_done", 128'(done), 128'd0);
    run(0, rnd256(), -1);
    for (int r = 0; r < 8; r++) run($urandom_range(0, 2), rnd256(), ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) : -1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
